// File: rtl/tar_sequencer.sv
// JTAG master sequencer: walks a downstream TAP through IR/DR shifts and TAP resets.
// Define TAR_SEQ_IDLE_WAIT_EN to add IDLE_CYCLES Run-Test/Idle cycles after each shift.
module tar_sequencer #(
  parameter int unsigned MAX_LEN      = 32,
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned IDLE_CYCLES  = 4,
  localparam int unsigned LenW        = $clog2(MAX_LEN + 1)
) (
  input  logic               tck_i,
  input  logic               trst_i,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_reset_i,
  input  logic               cmd_ir_i,
  input  logic [LenW-1:0]    cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  output logic [MAX_LEN-1:0] rsp_data_o
);

  localparam int unsigned IdxW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // One counter serves both the reset run and the post-shift wait.
  localparam int unsigned AuxMax = (RESET_CYCLES > IDLE_CYCLES) ? RESET_CYCLES : IDLE_CYCLES;
  localparam int unsigned AuxW   = (AuxMax > 1) ? $clog2(AuxMax) : 1;

  typedef enum logic [3:0] {
    StReset,
    StIdle,
    StSelDr,
    StSelIr,
    StCapture,
    StEnterShift,
    StShift,
    StUpdate,
    StReturn
`ifdef TAR_SEQ_IDLE_WAIT_EN
    , StWait
`endif
  } state_e;

  state_e             state_q, state_d;
  logic [AuxW-1:0]    aux_cnt_q, aux_cnt_d;
  logic [IdxW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IdxW-1:0]    len_m1_q, len_m1_d;
  logic               ir_q, ir_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic [LenW-1:0]    len_clamp;
  logic               last_bit;

  always_ff @(posedge tck_i) begin
    if (trst_i) begin
      state_q    <= StReset;
      aux_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      len_m1_q   <= '0;
      ir_q       <= 1'b0;
      data_q     <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      aux_cnt_q  <= aux_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      len_m1_q   <= len_m1_d;
      ir_q       <= ir_d;
      data_q     <= data_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    aux_cnt_d   = aux_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    len_m1_d    = len_m1_q;
    ir_d        = ir_q;
    data_d      = data_q;
    rsp_data_d  = rsp_data_q;
    tms_o       = 1'b0;
    tdi_o       = 1'b0;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    len_clamp   = (cmd_len_i > LenW'(MAX_LEN)) ? LenW'(MAX_LEN) : cmd_len_i;
    last_bit    = (bit_cnt_q == len_m1_q);

    unique case (state_q)
      StReset: begin
        tms_o = 1'b1;
        if (aux_cnt_q == AuxW'(RESET_CYCLES - 1)) begin
          aux_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          aux_cnt_d = aux_cnt_q + AuxW'(1);
        end
      end
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          rsp_data_d = '0;
          if (cmd_reset_i) begin
            aux_cnt_d = '0;
            state_d   = StReset;
          end else if (len_clamp == '0) begin
            // Zero-length shift: no TAP traffic, just the response pulse.
            state_d = StReturn;
          end else begin
            ir_d     = cmd_ir_i;
            len_m1_d = IdxW'(len_clamp - LenW'(1));
            data_d   = cmd_data_i;
            state_d  = StSelDr;
          end
        end
      end
      StSelDr: begin
        tms_o   = 1'b1;
        state_d = ir_q ? StSelIr : StCapture;
      end
      StSelIr: begin
        tms_o   = 1'b1;
        state_d = StCapture;
      end
      StCapture: begin
        state_d = StEnterShift;
      end
      StEnterShift: begin
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        tdi_o                 = data_q[bit_cnt_q];
        tms_o                 = last_bit;
        rsp_data_d[bit_cnt_q] = tdo_i;
        bit_cnt_d             = bit_cnt_q + IdxW'(1);
        if (last_bit) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        tms_o   = 1'b1;
        state_d = StReturn;
      end
      StReturn: begin
        rsp_valid_o = 1'b1;
`ifdef TAR_SEQ_IDLE_WAIT_EN
        aux_cnt_d   = '0;
        state_d     = StWait;
`else
        state_d     = StIdle;
`endif
      end
`ifdef TAR_SEQ_IDLE_WAIT_EN
      StWait: begin
        if (aux_cnt_q == AuxW'(IDLE_CYCLES - 1)) begin
          aux_cnt_d = '0;
          state_d   = StIdle;
        end else begin
          aux_cnt_d = aux_cnt_q + AuxW'(1);
        end
      end
`endif
      default: begin
        state_d = StReset;
      end
    endcase
  end

  assign rsp_data_o = rsp_data_q;

endmodule

// File: doc/tar_sequencer.md
Name: tar_sequencer

Overview:
JTAG master sequencer that drives a downstream TAP controller's TMS/TDI pins and captures TDO.
- Accepts one IR- or DR-shift command per valid/ready handshake.
- Walks the TAP from Run-Test/Idle through Select, Capture, Shift, Exit1 and Update back to Run-Test/Idle, returning the shifted-out bits.
- Also issues a TAP reset on command (TMS held high).
- Sits between the host/debug logic and tar_controller; shares its TCK/TRST.

Parameters:
MAX_LEN, 32, maximum shift length in bits; width of cmd_data/rsp_data.
RESET_CYCLES, 5, consecutive TMS=1 cycles issued for a TAP reset.
IDLE_CYCLES, 4, extra Run-Test/Idle cycles after each shift; used only with TAR_SEQ_IDLE_WAIT_EN.

Ports:
TCK  in  1  clock; all logic on rising edge.
TRST  in  1  synchronous active-high reset.
TMS  out  1  TAP mode select, decoded from state register.
TDI  out  1  TAP serial data out, LSB first.
TDO  in  1  TAP serial data in.
cmd_valid  in  1  command present.
cmd_ready  out  1  sequencer can accept a command.
cmd_reset  in  1  command is a TAP reset; other command fields ignored.
cmd_ir  in  1  1 = IR shift, 0 = DR shift.
cmd_len  in  clog2(MAX_LEN+1)  shift length in bits.
cmd_data  in  MAX_LEN  bits to shift in; bit 0 first.
rsp_valid  out  1  one-cycle pulse: shift complete.
rsp_data  out  MAX_LEN  bits captured from TDO; bit i = i-th bit out; unused upper bits 0.

Behaviour:
- Single clock TCK, synchronous active-high TRST.
- TRST=1 forces:
  - state=RESET, reset counter=0.
  - TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_data=0.
- TRST overrides everything, including mid-shift. The aborted command produces no rsp_valid.
- Each state drives a fixed TMS value during its cycle; the TAP consumes it on the next rising edge.
- States, with TMS driven and next state:
  - RESET: TMS=1 for RESET_CYCLES cycles, then IDLE.
  - IDLE: TMS=0, cmd_ready=1.
    - Accept on cmd_valid&cmd_ready.
    - cmd_reset=1 -> RESET.
    - Else -> SEL_DR.
  - SEL_DR: TMS=1 -> SEL_IR if cmd_ir, else CAPTURE.
  - SEL_IR: TMS=1 -> CAPTURE.
  - CAPTURE: TMS=0 -> ENTER_SHIFT.
  - ENTER_SHIFT: TMS=0 -> SHIFT, bit counter=0.
  - SHIFT: TDI=data[cnt]; TMS=(cnt==len-1).
    - On the ending edge: rsp_data[cnt] <= TDO, cnt++.
    - cnt==len-1 -> UPDATE.
  - UPDATE: TMS=1 -> RETURN.
  - RETURN: TMS=0, rsp_valid=1 (rsp_data final) -> IDLE.
- cmd_ready=1 only in IDLE. cmd_* fields are latched on accept; later changes are ignored.
- TDI=0 outside SHIFT.
- Latency, counted from the accept edge to the rsp_valid cycle:
  - DR: len+5 cycles.
  - IR: len+6 cycles.
  - The next command can be accepted the cycle after rsp_valid.
- cmd_len=0:
  - Accepted; no TAP traffic; stay in IDLE (TMS=0).
  - rsp_valid pulses the next cycle with rsp_data=0; cmd_ready=0 during that pulse cycle.
- cmd_len>MAX_LEN: clamped to MAX_LEN.
- rsp_data is cleared to 0 on accept. It holds its value after rsp_valid until the next accept.
- A reset command (cmd_reset) gives no rsp_valid.

Optional Feature:
TAR_SEQ_IDLE_WAIT_EN:
- Defined: after RETURN, enter WAIT for IDLE_CYCLES cycles (TMS=0, cmd_ready=0), then IDLE. rsp_valid still pulses in RETURN.
- Undefined: RETURN -> IDLE directly; IDLE_CYCLES ignored; no WAIT state.

Test Plan:
- Reset: TRST=1 for 2 cycles, then 0 -> TMS=1 for exactly 5 cycles, then TMS=0 with cmd_ready=1; rsp_valid stays 0.
- DR shift: cmd_ir=0, len=8, data=0xA5; TAP model shifts out 0x3C.
  - TMS = 1,0,0,0,0,0,0,0,0,0,1,1,0.
  - TDI during SHIFT = 1,0,1,0,0,1,0,1.
  - rsp_valid in cycle 13 after accept; rsp_data=0x3C.
- IR shift: cmd_ir=1, len=4, data=0x2; TAP returns 0x1.
  - TMS = 1,1,0,0,0,0,0,1,1,0.
  - rsp_valid in cycle 10; rsp_data=0x1.
- Single bit: len=1, DR -> TMS 1,0,0,1,1,0; one SHIFT cycle with TMS=1; rsp_valid in cycle 6.
- Abort: TRST=1 during the 3rd SHIFT cycle of a len=16 DR shift -> next cycle TMS=1, cmd_ready=0; 5 TMS=1 cycles, then IDLE; no rsp_valid.
- Boundaries:
  - len=0 -> rsp_valid the next cycle, rsp_data=0, TMS stays 0.
  - len=40 with MAX_LEN=32 -> 32 SHIFT cycles.
  - cmd_reset=1 -> 5 TMS=1 cycles, no rsp_valid.
  - With TAR_SEQ_IDLE_WAIT_EN: cmd_ready returns 5 cycles after rsp_valid (IDLE_CYCLES=4).
